// File: rtl/mac_neurona.sv
// Fixed-point MAC neuron: accumulates NumInputs Entrada*Peso products at full
// precision, then rescales by FracBits and saturates into Salida.
module mac_neurona #(
  parameter int Width     = 24,
  parameter int FracBits  = 10,
  parameter int NumInputs = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    Start,
  input  logic                    Dato_valido,
  input  logic signed [Width-1:0] Entrada,
  input  logic signed [Width-1:0] Peso,
  output logic                    Listo,
  output logic signed [Width-1:0] Salida,
  output logic                    Valido
);

  localparam int PW = 2 * Width;
  localparam int AW = PW + $clog2(NumInputs);
  localparam int CW = $clog2(NumInputs + 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-Width+1){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-Width+1){1'b1}}, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACUM, FIN} state_t;

  state_t                 state, state_nxt;
  logic signed [AW-1:0]   acc;
  logic [CW-1:0]          cnt;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   shifted;
  logic signed [Width-1:0] sat;
  logic                   take, last, start_ok;

  assign prod     = PW'(Entrada) * PW'(Peso);
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign take     = (state == ACUM) && Dato_valido;
  assign last     = (cnt == CW'(NumInputs - 1));
  assign start_ok = (state == IDLE) && Start;
  assign Listo    = (state == IDLE);

  // Floor rescale: arithmetic shift of the signed accumulator, then clamp.
  assign shifted = acc >>> FracBits;

  always_comb begin
    sat = shifted[Width-1:0];
    if (shifted > SAT_MAX)      sat = SAT_MAX[Width-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[Width-1:0];
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = ACUM;
      ACUM:    if (Dato_valido && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      cnt    <= '0;
      Salida <= '0;
      Valido <= 1'b0;
    end else begin
      Valido <= (state == FIN);
      if (start_ok) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc + prod_ext;
        cnt <= cnt + CW'(1);
      end
      if (state == FIN) Salida <= sat;
    end
  end

endmodule
